// File: rtl/coreport_wbm.sv
// coreport_wbm: single-transaction Wishbone classic master.
// Accepts one command over a valid/ready stream, runs one bus cycle (with
// retry reissue on wb_rty_i) and returns one response with status.
// Optional feature: define CORE_PORT_WBM_TIMEOUT_EN to abort cycles that no
// slave terminates within TIMEOUT bus cycles (status 2'b11).
module coreport_wbm #(
  parameter int WIDTH   = 8,
  parameter int RETRIES = 3,
  parameter int TIMEOUT = 255
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  // command stream
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [31:0]      cmd_adr,
  input  logic [WIDTH-1:0] cmd_dat,
  // response stream
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_dat,
  output logic [1:0]       rsp_status,
  // Wishbone master port
  output logic [31:0]      wb_adr_o,
  output logic [WIDTH-1:0] wb_dat_o,
  output logic             wb_we_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic [2:0]       wb_cti_o,
  output logic [1:0]       wb_bte_o,
  input  logic [WIDTH-1:0] wb_dat_i,
  input  logic             wb_ack_i,
  input  logic             wb_err_i,
  input  logic             wb_rty_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_RETRY = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] RS_OK  = 2'b00;
  localparam logic [1:0] RS_ERR = 2'b01;
  localparam logic [1:0] RS_RTY = 2'b10;
  localparam logic [3:0] RETRY_MAX = 4'(RETRIES);

  state_t           state_q, state_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic [1:0]       rsp_status_q, rsp_status_d;
  logic [31:0]      adr_q, adr_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic             we_q, we_d;
  logic             cyc_q, cyc_d;
  logic [3:0]       retry_cnt_q, retry_cnt_d;

`ifdef CORE_PORT_WBM_TIMEOUT_EN
  localparam logic [1:0] RS_TMO = 2'b11;
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d, to_cnt_inc;

  // Attempt timeout counter; cleared at command accept and on every reissue
  always_ff @(posedge wb_clk) begin
    if (wb_rst) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`endif

  // State and registered outputs
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q      <= ST_IDLE;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= 2'b00;
      adr_q        <= '0;
      dat_q        <= '0;
      we_q         <= 1'b0;
      cyc_q        <= 1'b0;
      retry_cnt_q  <= 4'd0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      we_q         <= we_d;
      cyc_q        <= cyc_d;
      retry_cnt_q  <= retry_cnt_d;
    end
  end

  // Next-state logic; terminations only matter while the strobe is up (BUS)
  always_comb begin
    state_d      = state_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    we_d         = we_q;
    cyc_d        = cyc_q;
    retry_cnt_d  = retry_cnt_q;
`ifdef CORE_PORT_WBM_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    // saturating increment so the counter can never wrap back to zero
    to_cnt_inc   = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + TO_W'(1);
`endif

    case (state_q)
      ST_IDLE: begin
        // cmd_ready_q rather than the state gates the accept, so nothing is
        // taken in the first cycle after reset
        if (cmd_valid && cmd_ready_q) begin
          adr_d       = cmd_adr;
          dat_d       = cmd_dat;
          we_d        = cmd_we;
          retry_cnt_d = 4'd0;
`ifdef CORE_PORT_WBM_TIMEOUT_EN
          to_cnt_d    = '0;
`endif
          cyc_d       = 1'b1;
          state_d     = ST_BUS;
        end
      end

      ST_BUS: begin
        if (wb_err_i) begin
          rsp_status_d = RS_ERR;
          rsp_dat_d    = '0;
          cyc_d        = 1'b0;
          state_d      = ST_RESP;
        end else if (wb_ack_i) begin
          rsp_status_d = RS_OK;
          rsp_dat_d    = we_q ? '0 : wb_dat_i;
          cyc_d        = 1'b0;
          state_d      = ST_RESP;
        end else if (wb_rty_i) begin
          cyc_d = 1'b0;
          if (retry_cnt_q < RETRY_MAX) begin
            retry_cnt_d = retry_cnt_q + 4'd1;
            state_d     = ST_RETRY;
          end else begin
            rsp_status_d = RS_RTY;
            rsp_dat_d    = '0;
            state_d      = ST_RESP;
          end
        end else begin
`ifdef CORE_PORT_WBM_TIMEOUT_EN
          to_cnt_d = to_cnt_inc;
          if (to_cnt_inc == TO_MAX) begin
            rsp_status_d = RS_TMO;
            rsp_dat_d    = '0;
            cyc_d        = 1'b0;
            state_d      = ST_RESP;
          end
`endif
        end
      end

      ST_RETRY: begin
        // one idle cycle with cyc/stb low, then reissue the same access
`ifdef CORE_PORT_WBM_TIMEOUT_EN
        to_cnt_d = '0;
`endif
        cyc_d   = 1'b1;
        state_d = ST_BUS;
      end

      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end

      default: begin
        cyc_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // handshake flags follow the state being entered so they are registered
    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_dat    = rsp_dat_q;
  assign rsp_status = rsp_status_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_we_o    = we_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign wb_cti_o   = 3'b000;
  assign wb_bte_o   = 2'b00;

endmodule

// File: tb/tb_coreport_wbm.sv
// Directed bench for coreport_wbm: vector table of single commands against a
// small behavioural slave, plus hand sequences for reset and ignored strobes.
module tb_coreport_wbm;

  localparam int WIDTH   = 8;
  localparam int RETRIES = 3;
  localparam int TIMEOUT = 8;

  typedef enum logic [2:0] {
    M_ACK, M_ERR, M_RTY, M_ERRACK, M_RTYACK, M_SILENT
  } mode_t;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [7:0]  dat;
    mode_t       mode;
    int          waits;
    logic [7:0]  rdata;
    logic [1:0]  exp_st;
    logic [7:0]  exp_dat;
    int          exp_cyc;
    int          exp_pulses;
    int          exp_lat;
  } vec_t;

  logic             wb_clk = 1'b0;
  logic             wb_rst;
  logic             cmd_valid, cmd_ready, cmd_we;
  logic [31:0]      cmd_adr;
  logic [WIDTH-1:0] cmd_dat;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_dat;
  logic [1:0]       rsp_status;
  logic [31:0]      wb_adr_o;
  logic [WIDTH-1:0] wb_dat_o, wb_dat_i;
  logic             wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0]       wb_cti_o;
  logic [1:0]       wb_bte_o;
  logic             wb_ack_i, wb_err_i, wb_rty_i;

  // slave model configuration, driven by the stimulus
  mode_t      s_mode;
  logic [3:0] s_waits;
  logic [7:0] s_rdata;
  logic       noise;
  logic [3:0] wcnt, att;
  logic       hit;

  int total = 0;
  int bad   = 0;

  always #5 wb_clk = ~wb_clk;

  coreport_wbm #(.WIDTH(WIDTH), .RETRIES(RETRIES), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_status(rsp_status),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o),
    .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  // wait-state and attempt counters of the slave model
  always @(posedge wb_clk) begin
    if (!wb_stb_o) wcnt <= 4'd0;
    else           wcnt <= wcnt + 4'd1;
    if (cmd_valid && cmd_ready)                        att <= 4'd0;
    else if (wb_stb_o && (wb_ack_i || wb_rty_i || wb_err_i)) att <= att + 4'd1;
  end

  // combinational slave terminations; noise forces all three regardless of stb
  always_comb begin
    hit      = wb_cyc_o && wb_stb_o && (wcnt == s_waits);
    wb_ack_i = noise;
    wb_err_i = noise;
    wb_rty_i = noise;
    wb_dat_i = hit ? s_rdata : 8'hEE;
    case (s_mode)
      M_ACK:    wb_ack_i = noise | hit;
      M_ERR:    wb_err_i = noise | hit;
      M_RTY:    wb_rty_i = noise | hit;
      M_ERRACK: begin wb_ack_i = noise | hit; wb_err_i = noise | hit; end
      M_RTYACK: begin
        if (att < 4'd2) wb_rty_i = noise | hit;
        else            wb_ack_i = noise | hit;
      end
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] adr, input logic [7:0] dat,
                              input mode_t mode, input int waits, input logic [7:0] rdata,
                              input logic [1:0] st, input logic [7:0] edat,
                              input int ecyc, input int epul, input int elat);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.mode = mode; v.waits = waits;
    v.rdata = rdata; v.exp_st = st; v.exp_dat = edat;
    v.exp_cyc = ecyc; v.exp_pulses = epul; v.exp_lat = elat;
    return v;
  endfunction

  // present a command, then watch the bus until rsp_valid (bounded)
  task automatic issue(input vec_t v, output int lat, output int cyc_n,
                       output int pulses, output int bus_bad);
    int   k;
    logic prev;
    s_mode  = v.mode;
    s_waits = 4'(v.waits);
    s_rdata = v.rdata;
    cmd_we  = v.we;
    cmd_adr = v.adr;
    cmd_dat = v.dat;
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 20) begin
      @(negedge wb_clk);
      k++;
    end
    chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    @(negedge wb_clk);
    cmd_valid = 1'b0;
    lat = 1; cyc_n = 0; pulses = 0; bus_bad = 0; prev = 1'b0;
    forever begin
      if (wb_cyc_o) begin
        cyc_n++;
        if (!prev) pulses++;
        if (wb_adr_o !== v.adr || wb_dat_o !== v.dat || wb_we_o !== v.we || !wb_stb_o)
          bus_bad++;
      end
      prev = wb_cyc_o;
      if (rsp_valid || lat >= 200) break;
      @(negedge wb_clk);
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat, cyc_n, pulses, bus_bad;
    issue(v, lat, cyc_n, pulses, bus_bad);
    $display("vec %0d: we=%0b adr=%08h lat=%0d cyc=%0d pulses=%0d status=%0b dat=%02h",
             idx, v.we, v.adr, lat, cyc_n, pulses, rsp_status, rsp_dat);
    chk($sformatf("v%0d_rsp_valid", idx), 64'(rsp_valid), 64'd1);
    chk($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.exp_lat));
    chk($sformatf("v%0d_status", idx), 64'(rsp_status), 64'(v.exp_st));
    chk($sformatf("v%0d_rsp_dat", idx), 64'(rsp_dat), 64'(v.exp_dat));
    chk($sformatf("v%0d_cyc_cycles", idx), 64'(cyc_n), 64'(v.exp_cyc));
    chk($sformatf("v%0d_stb_pulses", idx), 64'(pulses), 64'(v.exp_pulses));
    chk($sformatf("v%0d_bus_fields", idx), 64'(bus_bad), 64'd0);
    chk($sformatf("v%0d_adr_held", idx), {31'd0, wb_we_o, wb_adr_o}, {31'd0, v.we, v.adr});
    rsp_ready = 1'b1;
    @(negedge wb_clk);
    rsp_ready = 1'b0;
    chk($sformatf("v%0d_rsp_drop", idx), 64'(rsp_valid), 64'd0);
    chk($sformatf("v%0d_ready_back", idx), 64'(cmd_ready), 64'd1);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({cmd_ready, rsp_valid, rsp_dat, rsp_status, wb_adr_o, wb_dat_o,
                wb_we_o, wb_cyc_o, wb_stb_o});
  endfunction

  initial begin
    vec_t vecs[$];
    int   lat, cyc_n, pulses, bus_bad, ok, hs, rv;
    logic [7:0] held_dat;

    vecs.push_back(mk(1'b0, 32'h0000_0000, 8'h11, M_ACK,    0, 8'hA5, 2'b00, 8'hA5, 1, 1, 2));
    vecs.push_back(mk(1'b1, 32'h0000_0004, 8'h3C, M_ACK,    3, 8'h99, 2'b00, 8'h00, 4, 1, 5));
    vecs.push_back(mk(1'b0, 32'h0000_0010, 8'h22, M_RTY,    0, 8'h44, 2'b10, 8'h00, 4, 4, 8));
    vecs.push_back(mk(1'b0, 32'h0000_0020, 8'h33, M_ERRACK, 0, 8'h5A, 2'b01, 8'h00, 1, 1, 2));
    vecs.push_back(mk(1'b0, 32'h0000_0024, 8'h44, M_ERR,    2, 8'h66, 2'b01, 8'h00, 3, 1, 4));
    vecs.push_back(mk(1'b0, 32'hFFFF_FFFC, 8'h55, M_ACK,    1, 8'hFF, 2'b00, 8'hFF, 2, 1, 3));
    vecs.push_back(mk(1'b1, 32'h0000_0008, 8'h77, M_RTYACK, 0, 8'h12, 2'b00, 8'h00, 3, 3, 6));
    vecs.push_back(mk(1'b0, 32'h0000_0014, 8'h88, M_RTY,    1, 8'h34, 2'b10, 8'h00, 8, 4, 12));
`ifdef CORE_PORT_WBM_TIMEOUT_EN
    vecs.push_back(mk(1'b0, 32'h0000_0040, 8'h99, M_SILENT, 0, 8'h56, 2'b11, 8'h00, 8, 1, 9));
`endif

    wb_rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    rsp_ready = 1'b0; noise = 1'b0; s_mode = M_ACK; s_waits = 4'd0; s_rdata = 8'h00;

    // reset state
    @(negedge wb_clk);
    @(negedge wb_clk);
    chk("reset_outputs", all_outs(), 64'd0);
    chk("reset_cti_bte", {59'd0, wb_cti_o, wb_bte_o}, 64'd0);
    wb_rst = 1'b0;
    @(negedge wb_clk);
    chk("ready_after_reset", 64'(cmd_ready), 64'd1);

    // terminations with strobe low in IDLE are ignored
    noise = 1'b1;
    ok = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk);
      if (!wb_cyc_o && !rsp_valid && cmd_ready) ok++;
    end
    noise = 1'b0;
    $display("idle noise: quiet cycles=%0d", ok);
    chk("idle_noise_ignored", 64'(ok), 64'd3);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // issue rate: one command every 3 cycles with both streams always ready
    s_mode = M_ACK; s_waits = 4'd0; s_rdata = 8'h3E;
    cmd_we = 1'b0; cmd_adr = 32'h0000_0050; cmd_dat = 8'h00;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    hs = 0; rv = 0;
    for (int i = 0; i < 12; i++) begin
      if (cmd_ready) hs++;
      if (rsp_valid) rv++;
      @(negedge wb_clk);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    $display("issue rate: handshakes=%0d responses=%0d in 12 cycles", hs, rv);
    chk("rate_handshakes", 64'(hs), 64'd4);
    chk("rate_responses", 64'(rv), 64'd4);
    @(negedge wb_clk);

    // silent slave, then reset in the middle of the bus cycle
    s_mode = M_SILENT;
    cmd_we = 1'b1; cmd_adr = 32'h0000_0060; cmd_dat = 8'hC3; cmd_valid = 1'b1;
    ok = 0;
    while (!cmd_ready && ok < 20) begin
      @(negedge wb_clk);
      ok++;
    end
    @(negedge wb_clk);
    cmd_valid = 1'b0;
    ok = 0;
`ifdef CORE_PORT_WBM_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      if (wb_cyc_o && !rsp_valid) ok++;
      @(negedge wb_clk);
    end
    $display("silent slave: bus held %0d of 4 cycles", ok);
    chk("silent_bus_held", 64'(ok), 64'd4);
`else
    for (int i = 0; i < 120; i++) begin
      if (wb_cyc_o && !rsp_valid) ok++;
      @(negedge wb_clk);
    end
    $display("silent slave: bus held %0d of 120 cycles", ok);
    chk("silent_bus_held", 64'(ok), 64'd120);
`endif
    wb_rst = 1'b1;
    @(negedge wb_clk);
    $display("reset in BUS: outputs=%0h", all_outs());
    chk("reset_in_bus", all_outs(), 64'd0);
    wb_rst = 1'b0;
    @(negedge wb_clk);
    chk("bus_reset_ready", 64'(cmd_ready), 64'd1);
    run_vec(vecs[1], 101);

    // response held with rsp_ready low, noise ignored, then reset in RESP
    issue(mk(1'b0, 32'h0000_0030, 8'h00, M_ACK, 0, 8'h5C, 2'b00, 8'h5C, 1, 1, 2),
          lat, cyc_n, pulses, bus_bad);
    chk("resp_hold_lat", 64'(lat), 64'd2);
    held_dat = rsp_dat;
    noise = 1'b1;
    ok = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk);
      if (rsp_valid && rsp_dat == 8'h5C && rsp_status == 2'b00 && !wb_cyc_o && !cmd_ready) ok++;
    end
    noise = 1'b0;
    $display("resp hold: rsp_dat=%02h stable cycles=%0d", held_dat, ok);
    chk("resp_hold_stable", 64'(ok), 64'd3);
    wb_rst = 1'b1;
    @(negedge wb_clk);
    $display("reset in RESP: outputs=%0h", all_outs());
    chk("reset_in_resp", all_outs(), 64'd0);
    wb_rst = 1'b0;
    @(negedge wb_clk);
    chk("resp_reset_ready", 64'(cmd_ready), 64'd1);
    chk("resp_discarded", 64'(rsp_valid), 64'd0);
    run_vec(vecs[0], 102);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
